bip_datapath: RTL and testbench

- Execution datapath of the BIP single-cycle processor, directly downstream of the control unit.
- Consumes the 11-bit operand and the decoded controls: sel_a, sel_b, wr_acc, op_code, wr, rd.
- Holds the accumulator and status flags, performs add/sub, and drives the data-memory address and write-data ports.
- Data memory is external, with asynchronous (same-cycle) read.

---
 rtl/bip_pkg.sv | 42 ++++
 rtl/bip_alu.sv | 62 ++++++
 rtl/bip_datapath.sv | 130 +++++++++++++
 tb/tb_bip_datapath.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared encodings for the BIP execution datapath.
//   - accumulator source select (sel_a) encodings
//   - ALU B-operand select (sel_b) and ALU op encodings
//   - bit positions of the {N,Z,C,V} status flags and their reset value
//   - clogb2: ceiling log2, used to size the data-memory address
// -----------------------------------------------------------------------------
package bip_pkg;

  typedef enum logic [1:0] {
    SEL_A_MEM  = 2'b00,  // load from data memory
    SEL_A_IMM  = 2'b01,  // load sign-extended operand
    SEL_A_ALU  = 2'b10,  // load ALU result
    SEL_A_NONE = 2'b11   // hold, never writes the accumulator
  } sel_a_e;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // The accumulator resets to zero, so only Z is set.
  localparam logic [3:0] FLAGS_RST = 4'b0100;

  // Number of address bits needed to index `depth` words.
  function automatic int clogb2(input int depth);
    int result;
    result = 0;
    for (int val = depth - 1; val > 0; val = val >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bip_alu.sv
// -----------------------------------------------------------------------------
// bip_alu
// Combinational add/sub unit of the BIP datapath.
//   a, b  in  NB_BITS  operands (a is the accumulator)
//   op    in  1        OP_ADD / OP_SUB
//   res   out NB_BITS  result
//   c     out 1        carry out (add) or borrow (sub, a < b unsigned)
//   v     out 1        signed overflow
// Build option: BIP_SATURATE_EN clamps overflowing results to the most
// positive / most negative value instead of wrapping; v is still reported.
// -----------------------------------------------------------------------------
module bip_alu
  import bip_pkg::*;
#(
  parameter int NB_BITS = 16
) (
  input  logic [NB_BITS-1:0] a,
  input  logic [NB_BITS-1:0] b,
  input  logic               op,
  output logic [NB_BITS-1:0] res,
  output logic               c,
  output logic               v
);

  logic [NB_BITS:0] wide;
  logic             sign_a;
  logic             sign_b;
  logic             sign_r;

  // NOTE: every signal driven here gets a value on every path through the
  // block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    // One extra bit: for add it is the carry, for sub it is set exactly
    // when the unsigned subtraction borrows.
    if (op == OP_ADD) begin
      wide = {1'b0, a} + {1'b0, b};
    end else begin
      wide = {1'b0, a} - {1'b0, b};
    end

    sign_a = a[NB_BITS-1];
    sign_b = b[NB_BITS-1];
    sign_r = wide[NB_BITS-1];
    c      = wide[NB_BITS];

    if (op == OP_ADD) begin
      v = (sign_a == sign_b) && (sign_r != sign_a);
    end else begin
      v = (sign_a != sign_b) && (sign_r != sign_a);
    end

    res = wide[NB_BITS-1:0];
`ifdef BIP_SATURATE_EN
    // In both add and sub, an overflow always goes in the direction of a's
    // sign: a non-negative a can only overflow upwards.
    if (v) begin
      res = sign_a ? {1'b1, {(NB_BITS-1){1'b0}}} : {1'b0, {(NB_BITS-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/bip_datapath.sv
// -----------------------------------------------------------------------------
// bip_datapath
// Execution datapath of the BIP single-cycle processor. Holds the
// accumulator, the {N,Z,C,V} flags and a count of accumulator writes, and
// drives an external data memory with same-cycle read.
//
// Ports:
//   i_clk         in   1        clock, rising edge
//   i_rst         in   1        synchronous reset, active-low
//   i_data_ins    in   NB_SIGX  operand field from control
//   i_sel_a       in   2        accumulator source (see bip_pkg::sel_a_e)
//   i_sel_b       in   1        ALU B select: memory data / immediate
//   i_wr_acc      in   1        accumulator write enable
//   i_op_code     in   1        1 = add, 0 = sub
//   i_wr          in   1        data-memory write request
//   i_rd          in   1        data-memory read request
//   i_mem_rdata   in   NB_BITS  data-memory read data (same cycle)
//   o_mem_addr    out  NB_ADDR  data-memory address (low operand bits)
//   o_mem_wdata   out  NB_BITS  data-memory write data (current acc)
//   o_mem_wr      out  1        data-memory write strobe
//   o_mem_rd      out  1        data-memory read strobe
//   o_acc         out  NB_BITS  accumulator
//   o_flags       out  4        {N,Z,C,V}
//   o_acc_wr_cnt  out  NB_CNT   accumulator writes since reset (wraps)
//
// Build option: BIP_SATURATE_EN (see bip_alu).
// -----------------------------------------------------------------------------
module bip_datapath
  import bip_pkg::*;
#(
  parameter  int NB_BITS        = 16,
  parameter  int NB_SIGX        = 11,
  parameter  int DATA_MEM_DEPTH = 1024,
  parameter  int NB_CNT         = 32,
  localparam int NB_ADDR        = clogb2(DATA_MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_SIGX-1:0] i_data_ins,
  input  logic [1:0]         i_sel_a,
  input  logic               i_sel_b,
  input  logic               i_wr_acc,
  input  logic               i_op_code,
  input  logic               i_wr,
  input  logic               i_rd,
  input  logic [NB_BITS-1:0] i_mem_rdata,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_BITS-1:0] o_mem_wdata,
  output logic               o_mem_wr,
  output logic               o_mem_rd,
  output logic [NB_BITS-1:0] o_acc,
  output logic [3:0]         o_flags,
  output logic [NB_CNT-1:0]  o_acc_wr_cnt
);

  sel_a_e             sel_a;
  logic [NB_BITS-1:0] imm;
  logic [NB_BITS-1:0] alu_b;
  logic [NB_BITS-1:0] alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               acc_we;

  logic [NB_BITS-1:0] acc;
  logic [NB_BITS-1:0] acc_next;
  logic [3:0]         flags;
  logic [3:0]         flags_next;
  logic [NB_CNT-1:0]  cnt;

  assign sel_a = sel_a_e'(i_sel_a);
  assign imm   = {{(NB_BITS-NB_SIGX){i_data_ins[NB_SIGX-1]}}, i_data_ins};
  assign alu_b = (i_sel_b == SEL_B_IMM) ? imm : i_mem_rdata;

  // SEL_A_NONE suppresses the write even when i_wr_acc is asserted.
  assign acc_we = i_wr_acc && (sel_a != SEL_A_NONE);

  bip_alu #(
    .NB_BITS (NB_BITS)
  ) u_alu (
    .a   (acc),
    .b   (alu_b),
    .op  (i_op_code),
    .res (alu_res),
    .c   (alu_c),
    .v   (alu_v)
  );

  always_comb begin
    acc_next = acc;
    case (sel_a)
      SEL_A_MEM: acc_next = i_mem_rdata;
      SEL_A_IMM: acc_next = imm;
      SEL_A_ALU: acc_next = alu_res;
      default:   acc_next = acc;
    endcase

    // N/Z follow the value being written; C/V only carry meaning for
    // arithmetic and are cleared by plain loads.
    flags_next        = flags;
    flags_next[FLG_N] = acc_next[NB_BITS-1];
    flags_next[FLG_Z] = (acc_next == '0);
    flags_next[FLG_C] = (sel_a == SEL_A_ALU) ? alu_c : 1'b0;
    flags_next[FLG_V] = (sel_a == SEL_A_ALU) ? alu_v : 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc   <= '0;
      flags <= FLAGS_RST;
      cnt   <= '0;
    end else if (acc_we) begin
      acc   <= acc_next;
      flags <= flags_next;
      cnt   <= cnt + NB_CNT'(1);
    end
  end

  // Write data is the registered accumulator, so a store issued together
  // with an accumulator write sees the old value.
  assign o_mem_addr   = i_data_ins[NB_ADDR-1:0];
  assign o_mem_wdata  = acc;
  assign o_mem_wr     = i_wr & i_rst;
  assign o_mem_rd     = i_rd & i_rst;
  assign o_acc        = acc;
  assign o_flags      = flags;
  assign o_acc_wr_cnt = cnt;

endmodule

// File: tb/tb_bip_datapath.sv
// -----------------------------------------------------------------------------
// tb_bip_datapath
// Self-checking bench for bip_datapath (built with NB_CNT=4 so the counter
// wrap is reachable). A behavioural model evaluated with integer arithmetic
// is compared against every output on each falling edge; directed steps add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bip_datapath;

  localparam int NB_BITS = 16;
  localparam int NB_SIGX = 11;
  localparam int NB_CNT  = 4;

  logic               clk;
  logic               i_rst;
  logic [NB_SIGX-1:0] i_data_ins;
  logic [1:0]         i_sel_a;
  logic               i_sel_b;
  logic               i_wr_acc;
  logic               i_op_code;
  logic               i_wr;
  logic               i_rd;
  logic [NB_BITS-1:0] i_mem_rdata;
  logic [9:0]         o_mem_addr;
  logic [NB_BITS-1:0] o_mem_wdata;
  logic               o_mem_wr;
  logic               o_mem_rd;
  logic [NB_BITS-1:0] o_acc;
  logic [3:0]         o_flags;
  logic [NB_CNT-1:0]  o_acc_wr_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  bip_datapath #(
    .NB_BITS        (NB_BITS),
    .NB_SIGX        (NB_SIGX),
    .DATA_MEM_DEPTH (1024),
    .NB_CNT         (NB_CNT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_data_ins   (i_data_ins),
    .i_sel_a      (i_sel_a),
    .i_sel_b      (i_sel_b),
    .i_wr_acc     (i_wr_acc),
    .i_op_code    (i_op_code),
    .i_wr         (i_wr),
    .i_rd         (i_rd),
    .i_mem_rdata  (i_mem_rdata),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wr     (o_mem_wr),
    .o_mem_rd     (o_mem_rd),
    .o_acc        (o_acc),
    .o_flags      (o_flags),
    .o_acc_wr_cnt (o_acc_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp = n_cmp + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: state as plain integers, arithmetic done on signed and
  // unsigned integer views of the operands.
  // ---------------------------------------------------------------------------
  int m_acc   = 0;
  int m_flags = 0;
  int m_cnt   = 0;
  bit model_valid = 1'b0;

  function automatic int to_signed16(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  always @(posedge clk) begin : model
    int imm_u, b_u, a_s, b_s, sres, res;
    bit c, v;
    if (!i_rst) begin
      m_acc       = 0;
      m_flags     = 4;
      m_cnt       = 0;
      model_valid = 1'b1;
    end else if (i_wr_acc && i_sel_a != 2'b11) begin
      imm_u = i_data_ins[10] ? (int'(i_data_ins) - 2048) & 65535 : int'(i_data_ins);
      c = 1'b0;
      v = 1'b0;
      if (i_sel_a == 2'b00) begin
        res = int'(i_mem_rdata);
      end else if (i_sel_a == 2'b01) begin
        res = imm_u;
      end else begin
        b_u = i_sel_b ? imm_u : int'(i_mem_rdata);
        a_s = to_signed16(m_acc);
        b_s = to_signed16(b_u);
        if (i_op_code) begin
          c    = (m_acc + b_u) > 65535;
          sres = a_s + b_s;
        end else begin
          c    = m_acc < b_u;
          sres = a_s - b_s;
        end
        v   = (sres > 32767) || (sres < -32768);
        res = sres & 65535;
`ifdef BIP_SATURATE_EN
        if (v) res = (sres > 0) ? 32'h7FFF : 32'h8000;
`endif
      end
      m_acc   = res;
      m_flags = ((res >= 32768) ? 8 : 0) + ((res == 0) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
      m_cnt   = (m_cnt + 1) % 16;
    end
  end

  // Compare process: every output, every cycle once the model is defined.
  always @(negedge clk) begin
    if (model_valid) begin
      check("acc",      32'(o_acc),        32'(m_acc));
      check("flags",    32'(o_flags),      32'(m_flags));
      check("cnt",      32'(o_acc_wr_cnt), 32'(m_cnt));
      check("wdata",    32'(o_mem_wdata),  32'(m_acc));
      check("addr",     32'(o_mem_addr),   32'(int'(i_data_ins) % 1024));
      check("mem_wr",   32'(o_mem_wr),     32'(i_wr && i_rst));
      check("mem_rd",   32'(o_mem_rd),     32'(i_rd && i_rst));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic set_in(input logic rst, input logic [10:0] ins, input logic [1:0] sa,
                        input logic sb, input logic wa, input logic op,
                        input logic wr, input logic rd, input logic [15:0] rdata);
    i_rst       = rst;
    i_data_ins  = ins;
    i_sel_a     = sa;
    i_sel_b     = sb;
    i_wr_acc    = wa;
    i_op_code   = op;
    i_wr        = wr;
    i_rd        = rd;
    i_mem_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_imm(input logic [10:0] ins);
    set_in(1'b1, ins, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
  endtask

  task automatic load_mem(input logic [15:0] rdata);
    set_in(1'b1, 11'h000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rdata);
    tick();
  endtask

  initial begin
    // Reset held two cycles while control asks for a write.
    set_in(1'b0, 11'h005, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0);
    #1;
    check("strobe_wr_in_reset", 32'(o_mem_wr), 32'd0);
    check("strobe_rd_in_reset", 32'(o_mem_rd), 32'd0);
    tick();
    tick();
    check("rst_acc",   32'(o_acc),        32'h0);
    check("rst_flags", 32'(o_flags),      32'h4);
    check("rst_cnt",   32'(o_acc_wr_cnt), 32'h0);

    // Sign-extended immediate loads.
    load_imm(11'h7FF);
    check("ldi_neg_acc",   32'(o_acc),        32'hFFFF);
    check("ldi_neg_flags", 32'(o_flags),      32'h8);
    check("ldi_neg_cnt",   32'(o_acc_wr_cnt), 32'd1);
    load_imm(11'h3FF);
    check("ldi_pos_acc",   32'(o_acc),        32'h03FF);

    // Load from memory with address wrap, then store with acc held.
    set_in(1'b1, 11'h405, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    #1;
    check("ld_addr_wrap", 32'(o_mem_addr), 32'h005);
    tick();
    check("ld_acc", 32'(o_acc), 32'h1234);
    set_in(1'b1, 11'h405, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    #1;
    check("st_wdata", 32'(o_mem_wdata), 32'h1234);
    check("st_wr",    32'(o_mem_wr),    32'd1);
    tick();
    check("st_acc_hold", 32'(o_acc),        32'h1234);
    check("st_cnt_hold", 32'(o_acc_wr_cnt), 32'd3);

    // 0x7FFF + 1: positive overflow.
    load_mem(16'h7FFF);
    set_in(1'b1, 11'h001, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
`ifdef BIP_SATURATE_EN
    check("add_ovf_acc",   32'(o_acc),   32'h7FFF);
    check("add_ovf_flags", 32'(o_flags), 32'h1);
`else
    check("add_ovf_acc",   32'(o_acc),   32'h8000);
    check("add_ovf_flags", 32'(o_flags), 32'h9);
`endif

    // 3 - mem 5: borrow, negative, no overflow.
    load_imm(11'h003);
    set_in(1'b1, 11'h000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005);
    tick();
    check("sub_borrow_acc",   32'(o_acc),   32'hFFFE);
    check("sub_borrow_flags", 32'(o_flags), 32'hA);

    // 5 - imm 5: zero.
    load_imm(11'h005);
    set_in(1'b1, 11'h005, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    check("sub_zero_acc",   32'(o_acc),   32'h0000);
    check("sub_zero_flags", 32'(o_flags), 32'h4);
    check("sub_zero_cnt",   32'(o_acc_wr_cnt), 32'd9);

    // Halt: 10 cycles of all-zero controls.
    set_in(1'b1, 11'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    repeat (10) tick();
    check("halt_acc",   32'(o_acc),        32'h0000);
    check("halt_flags", 32'(o_flags),      32'h4);
    check("halt_cnt",   32'(o_acc_wr_cnt), 32'd9);

    // Store and accumulate in the same cycle.
    load_imm(11'h010);
    set_in(1'b1, 11'h001, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    #1;
    check("simul_wdata", 32'(o_mem_wdata), 32'h0010);
    tick();
    check("simul_acc", 32'(o_acc), 32'h0011);

    // 0xFFFF + 1: carry out to zero, no signed overflow.
    load_imm(11'h7FF);
    set_in(1'b1, 11'h001, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    tick();
    check("add_carry_acc",   32'(o_acc),   32'h0000);
    check("add_carry_flags", 32'(o_flags), 32'h6);

    // 0x8000 - 1: negative overflow.
    load_mem(16'h8000);
    set_in(1'b1, 11'h001, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
`ifdef BIP_SATURATE_EN
    check("sub_ovf_acc",   32'(o_acc),   32'h8000);
    check("sub_ovf_flags", 32'(o_flags), 32'h9);
`else
    check("sub_ovf_acc",   32'(o_acc),   32'h7FFF);
    check("sub_ovf_flags", 32'(o_flags), 32'h1);
`endif
    check("pre_wrap_cnt", 32'(o_acc_wr_cnt), 32'd15);

    // Counter wraps from all-ones.
    load_imm(11'h02A);
    check("wrap_cnt", 32'(o_acc_wr_cnt), 32'd0);
    check("wrap_acc", 32'(o_acc),        32'h002A);

    // Reset overrides a concurrent accumulator write.
    set_in(1'b0, 11'h007, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    check("midrst_acc",   32'(o_acc),        32'h0);
    check("midrst_flags", 32'(o_flags),      32'h4);
    check("midrst_cnt",   32'(o_acc_wr_cnt), 32'h0);
    set_in(1'b1, 11'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
